// File: rtl/icache_fill_ctrl_if.sv
// Fetch-side bundle for the instruction-cache fill controller.
//   master : PC / decode / imem side (drives address, redirects, line data)
//   slave  : the cache controller (returns hit, instruction, status, counters)
// Signals:
//   a          fetch address (word aligned)
//   pcsrcD     taken branch in Decode
//   jumpD      jump in Decode
//   branchD    branch type in Decode, nonzero = redirect pending
//   mem_rd     512-bit line from imem, word k at [32k+31:32k]
//   mem_ready  one-cycle line-valid strobe from imem
//   hit        tag match, 0 doubles as the fill request to imem
//   instrF     fetched instruction, zero on a miss
//   fill_busy  high while a fill is outstanding
//   hit_cnt    saturating hit-cycle counter
//   miss_cnt   saturating line-install counter
interface icache_fill_ctrl_if #(
  parameter int unsigned CNTW = 16
);
  logic [31:0]     a;
  logic            pcsrcD;
  logic            jumpD;
  logic [1:0]      branchD;
  logic [511:0]    mem_rd;
  logic            mem_ready;
  logic            hit;
  logic [31:0]     instrF;
  logic            fill_busy;
  logic [CNTW-1:0] hit_cnt;
  logic [CNTW-1:0] miss_cnt;

  modport master (
    output a, pcsrcD, jumpD, branchD, mem_rd, mem_ready,
    input  hit, instrF, fill_busy, hit_cnt, miss_cnt
  );

  modport slave (
    input  a, pcsrcD, jumpD, branchD, mem_rd, mem_ready,
    output hit, instrF, fill_busy, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped, read-only instruction cache that fills whole 512-bit lines
// from imem on a miss. Lookup is purely combinational; a miss moves the FSM
// to FILL until imem strobes mem_ready (install) or a Decode redirect aborts.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    icache_fill_ctrl_if.slave (address, redirects, line data in;
//          hit, instrF, fill_busy, hit_cnt, miss_cnt out)
module icache_fill_ctrl #(
  parameter int unsigned NLINES = 16,
  parameter int unsigned CNTW   = 16
) (
  input logic               clk,
  input logic               reset,
  icache_fill_ctrl_if.slave bus
);

  localparam int unsigned IDXW = $clog2(NLINES);
  localparam int unsigned TAGW = 26 - IDXW;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [511:0]    data_q [NLINES];
  logic [TAGW-1:0] tag_q  [NLINES];
  logic [NLINES-1:0] valid_q;
  logic [CNTW-1:0] hit_cnt_q;
  logic [CNTW-1:0] miss_cnt_q;

  logic [3:0]      offset;
  logic [IDXW-1:0] index;
  logic [TAGW-1:0] tag;
  logic            abort;
  logic            hit;
  logic            install;
  logic            unused_ok;

  assign offset = bus.a[5:2];
  assign index  = bus.a[6+IDXW-1:6];
  assign tag    = bus.a[31:6+IDXW];
  assign unused_ok = &{1'b0, bus.a[1:0]};

  assign abort = bus.pcsrcD | bus.jumpD | (bus.branchD != 2'b00);
  assign hit   = valid_q[index] && (tag_q[index] == tag);

  // The install uses whatever address is present in the mem_ready cycle;
  // imem reads that same address, so tag and data always agree.
  assign install = (state_q == FILL) && bus.mem_ready && !abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!hit && !abort) state_d = FILL;
      FILL: if (abort || bus.mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (install) begin
        valid_q[index] <= 1'b1;
      end
      if (hit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + CNTW'(1);
      end
      if (install && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNTW'(1);
      end
    end
  end

  // Data and tag arrays carry no reset; valid_q alone gates their use.
  always_ff @(posedge clk) begin
    if (install) begin
      data_q[index] <= bus.mem_rd;
      tag_q[index]  <= tag;
    end
  end

  assign bus.hit       = hit;
  assign bus.instrF    = hit ? data_q[index][{offset, 5'd0} +: 32] : '0;
  assign bus.fill_busy = (state_q == FILL);
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
module tb_icache_fill_ctrl;

  logic         clk = 1'b1;
  logic         reset;
  logic [31:0]  a;
  logic         pcsrcD;
  logic         jumpD;
  logic [1:0]   branchD;
  logic [511:0] mem_rd;
  logic         mem_ready;

  always #5 clk = ~clk;

  icache_fill_ctrl_if #(.CNTW(16)) ifc ();
  icache_fill_ctrl_if #(.CNTW(4))  ifs ();

  assign ifc.a = a;        assign ifs.a = a;
  assign ifc.pcsrcD = pcsrcD;   assign ifs.pcsrcD = pcsrcD;
  assign ifc.jumpD = jumpD;     assign ifs.jumpD = jumpD;
  assign ifc.branchD = branchD; assign ifs.branchD = branchD;
  assign ifc.mem_rd = mem_rd;   assign ifs.mem_rd = mem_rd;
  assign ifc.mem_ready = mem_ready; assign ifs.mem_ready = mem_ready;

  icache_fill_ctrl #(.NLINES(16), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );
  icache_fill_ctrl #(.NLINES(16), .CNTW(4)) dut_s (
    .clk(clk), .reset(reset), .bus(ifs)
  );

  typedef struct {
    logic        hit;
    logic [31:0] instr;
    logic        busy;
    logic [15:0] hc;
    logic [15:0] mc;
    logic [3:0]  hcs;
    logic [3:0]  mcs;
    bit          pin;
    logic [31:0] pi;
    logic [15:0] pm;
    bit          pin_s;
    logic [3:0]  phcs;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // Reference cache: contents kept as plain words per line.
  logic        mvalid [16];
  logic [21:0] mtag   [16];
  logic [31:0] mdata  [16][16];
  bit          mfill;
  int          mhits, mmiss, icnt;

  bit          pin_en;
  logic [31:0] pin_instr;
  logic [15:0] pin_mc;
  bit          pin_s_en;
  logic [3:0]  pin_hcs;

  function automatic logic [31:0] ramw(input logic [31:0] addr, input int k);
    return ((addr >> 2) & ~32'hF) + 32'(k) + 32'd1;
  endfunction

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc_n, act, req);
    end
  endtask

  // mode: 0 = imem model timing, 1 = force mem_ready=1, 2 = force 0
  task automatic cyc(input logic [31:0] aa, input logic pc, input logic jm,
                     input logic [1:0] br, input int mode, input logic rs);
    exp_t        e;
    logic        ab, hm, mr;
    int          ix, off;
    logic [21:0] tg;
    a = aa; pcsrcD = pc; jumpD = jm; branchD = br; reset = rs;
    ix  = int'(aa[9:6]);
    off = int'(aa[5:2]);
    tg  = aa[31:10];
    for (int k = 0; k < 16; k++) mem_rd[32*k +: 32] = ramw(aa, k);
    if (rs) begin
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
      mfill = 0; mhits = 0; mmiss = 0; icnt = 0;
    end
    ab = pc | jm | (br != 2'b00);
    hm = mvalid[ix] && (mtag[ix] == tg);
    mr = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (!hm && icnt == 19);
    mem_ready = mr;
    e.hit   = hm;
    e.instr = hm ? mdata[ix][off] : 32'd0;
    e.busy  = mfill;
    e.hc    = sat16(mhits);
    e.mc    = sat16(mmiss);
    e.hcs   = sat4(mhits);
    e.mcs   = sat4(mmiss);
    e.pin   = pin_en;   e.pi = pin_instr; e.pm = pin_mc;
    e.pin_s = pin_s_en; e.phcs = pin_hcs;
    sbq.push_back(e);
    pin_en = 0; pin_s_en = 0;
    if (!rs) begin
      if (hm) mhits++;
      if (!mfill) mfill = !hm && !ab;
      else if (ab) mfill = 0;
      else if (mr) begin
        mvalid[ix] = 1'b1;
        mtag[ix]   = tg;
        for (int k = 0; k < 16; k++) mdata[ix][k] = ramw(aa, k);
        mmiss++;
        mfill = 0;
      end
    end
    if (rs || hm || mr) icnt = 0;
    else if (!ab) icnt++;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic pin(input logic [31:0] pi, input logic [15:0] pm);
    pin_en = 1; pin_instr = pi; pin_mc = pm;
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("hit",       {31'd0, ifc.hit},       {31'd0, e.hit});
      chk("instrF",    ifc.instrF,             e.instr);
      chk("fill_busy", {31'd0, ifc.fill_busy}, {31'd0, e.busy});
      chk("hit_cnt",   {16'd0, ifc.hit_cnt},   {16'd0, e.hc});
      chk("miss_cnt",  {16'd0, ifc.miss_cnt},  {16'd0, e.mc});
      chk("hit_cnt_sat",  {28'd0, ifs.hit_cnt},  {28'd0, e.hcs});
      chk("miss_cnt_sat", {28'd0, ifs.miss_cnt}, {28'd0, e.mcs});
      chk("hit_s",     {31'd0, ifs.hit},       {31'd0, e.hit});
      if (e.pin) begin
        chk("pin_instrF",   ifc.instrF,           e.pi);
        chk("pin_miss_cnt", {16'd0, ifc.miss_cnt}, {16'd0, e.pm});
      end
      if (e.pin_s) chk("pin_hit_cnt_sat", {28'd0, ifs.hit_cnt}, {28'd0, e.phcs});
    end
  end

  initial begin
    logic [31:0] ra;
    int          r;
    pin_en = 0; pin_s_en = 0; pin_instr = '0; pin_mc = '0; pin_hcs = '0;
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0; mtag[i] = '0;
      for (int k = 0; k < 16; k++) mdata[i][k] = '0;
    end
    mfill = 0; mhits = 0; mmiss = 0; icnt = 0;

    // Cold miss at 0x0: mem_ready on the 20th cycle, hit the cycle after.
    cyc(32'h0, 0, 0, 2'd0, 2, 1);
    cyc(32'h0, 0, 0, 2'd0, 1, 1);
    for (int i = 0; i < 20; i++) cyc(32'h0, 0, 0, 2'd0, 0, 0);
    pin(32'd1, 16'd1);
    cyc(32'h0, 0, 0, 2'd0, 0, 0);

    // Line reuse across the remaining 15 words.
    for (int i = 1; i < 16; i++) begin
      pin(32'(i + 1), 16'd1);
      cyc(32'(4 * i), 0, 0, 2'd0, 0, 0);
    end

    // Conflict eviction: 0x400 shares index 0 with 0x0.
    for (int i = 0; i < 20; i++) cyc(32'h400, 0, 0, 2'd0, 0, 0);
    pin(32'd257, 16'd2);
    cyc(32'h400, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(32'h0, 0, 0, 2'd0, 0, 0);
    pin(32'd1, 16'd3);
    cyc(32'h0, 0, 0, 2'd0, 0, 0);

    // Abort coincident with mem_ready discards the line.
    for (int i = 0; i < 19; i++) cyc(32'h800, 0, 0, 2'd0, 0, 0);
    cyc(32'h800, 1, 0, 2'd0, 1, 0);
    pin(32'd0, 16'd3);
    cyc(32'h800, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 19; i++) cyc(32'h800, 0, 0, 2'd0, 0, 0);
    pin(32'd513, 16'd4);
    cyc(32'h800, 0, 0, 2'd0, 0, 0);

    // Reset 10 cycles into FILL on a warm cache.
    for (int i = 0; i < 11; i++) cyc(32'h0, 0, 0, 2'd0, 0, 0);
    pin(32'd0, 16'd0);
    cyc(32'h0, 0, 0, 2'd0, 0, 1);
    cyc(32'h800, 0, 0, 2'd0, 0, 1);
    pin(32'd0, 16'd0);
    cyc(32'h800, 0, 0, 2'd0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(32'h800, 0, 0, 2'd0, 0, 0);
    pin(32'd513, 16'd1);
    cyc(32'h800, 0, 0, 2'd0, 0, 0);

    // Saturation of the 4-bit counter instance.
    for (int i = 0; i < 20; i++) cyc(32'h800 + 32'(4 * (i % 16)), 0, 0, 2'd0, 0, 0);
    pin_s_en = 1; pin_hcs = 4'hF;
    cyc(32'h804, 0, 0, 2'd0, 0, 0);

    // Randomized traffic over a small conflicting address pool.
    ra = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      logic       pc, jm;
      logic [1:0] br;
      if ($urandom_range(0, 3) == 0)
        ra = {20'($urandom_range(0, 2)), 2'b00, 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 2'b00};
      r  = int'($urandom_range(0, 15));
      pc = (r == 0);
      jm = (r == 1);
      br = (r == 2) ? 2'($urandom_range(1, 3)) : 2'd0;
      cyc(ra, pc, jm, br, ($urandom_range(0, 31) == 0) ? 1 : 0,
          ($urandom_range(0, 499) == 0));
    end

    @(posedge clk);
    #1;
    chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
